// File: rtl/uart_pkg.sv
// uart_pkg: shared UART receiver state encoding and frame constants
package uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, CLEANUP} uart_state_e;
  localparam int CLKS_PER_BIT_115200 = 217;
  localparam int UART_DATA_BITS = 8;
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer for asynchronous inputs with a selectable reset level
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic i_clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q
);
  logic r_meta;
  logic r_q;
  always_ff @(posedge i_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= RST_VAL;
      r_q    <= RST_VAL;
    end else begin
      r_meta <= i_d;
      r_q    <= r_meta;
    end
  end
  assign o_q = r_q;
endmodule

// File: rtl/uart_rx_byte.sv
// uart_rx_byte: 8N1 UART receiver producing a byte and a one-cycle valid pulse
// Define UART_RX_FRAME_ERR_EN to check the stop bit and add the o_Frame_Err port.
module uart_rx_byte
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_115200
) (
  input  logic       i_Clk,
  input  logic       rst_n,
  input  logic       i_RX_Serial,
  output logic       o_RX_DV,
  output logic [7:0] o_RX_Byte
`ifdef UART_RX_FRAME_ERR_EN
  ,
  output logic       o_Frame_Err
`endif
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] C_MID  = CW'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CW-1:0] C_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [2:0] C_LAST_BIT = 3'(UART_DATA_BITS - 1);
  logic          w_rx_s;
  uart_state_e   r_state;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_bit_idx;
  logic [7:0]    r_shift;
  logic [7:0]    r_byte;
  logic          r_dv;
`ifdef UART_RX_FRAME_ERR_EN
  logic          r_ferr;
  assign o_Frame_Err = r_ferr;
`endif
  sync_2ff #(.RST_VAL(1'b1)) u_sync (
    .i_clk (i_Clk),
    .rst_n (rst_n),
    .i_d   (i_RX_Serial),
    .o_q   (w_rx_s)
  );
  // Start is checked mid-bit; data/stop then land mid-bit every CLKS_PER_BIT cycles.
  always_ff @(posedge i_Clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_byte    <= '0;
      r_dv      <= 1'b0;
`ifdef UART_RX_FRAME_ERR_EN
      r_ferr    <= 1'b0;
`endif
    end else begin
      r_dv <= 1'b0;
`ifdef UART_RX_FRAME_ERR_EN
      r_ferr <= 1'b0;
`endif
      case (r_state)
        IDLE: begin
          r_cnt     <= '0;
          r_bit_idx <= '0;
          if (!w_rx_s) r_state <= START;
        end
        START: begin
          if (r_cnt == C_MID) begin
            r_cnt   <= '0;
            r_state <= w_rx_s ? IDLE : DATA;
          end else r_cnt <= r_cnt + CW'(1);
        end
        DATA: begin
          if (r_cnt == C_LAST) begin
            r_cnt              <= '0;
            r_shift[r_bit_idx] <= w_rx_s;
            r_bit_idx          <= r_bit_idx + 3'd1;
            if (r_bit_idx == C_LAST_BIT) r_state <= STOP;
          end else r_cnt <= r_cnt + CW'(1);
        end
        STOP: begin
          if (r_cnt == C_LAST) begin
            r_cnt   <= '0;
            r_state <= CLEANUP;
`ifdef UART_RX_FRAME_ERR_EN
            if (w_rx_s) begin
              r_dv   <= 1'b1;
              r_byte <= r_shift;
            end else r_ferr <= 1'b1;
`else
            r_dv   <= 1'b1;
            r_byte <= r_shift;
`endif
          end else r_cnt <= r_cnt + CW'(1);
        end
        CLEANUP: r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end
  assign o_RX_DV   = r_dv;
  assign o_RX_Byte = r_byte;
endmodule

// File: tb/tb_uart_rx_byte.sv
// tb_uart_rx_byte: self-checking bench for uart_rx_byte (CLKS_PER_BIT=8)
module tb_uart_rx_byte;
  localparam int CPB = 8;
  localparam int LAT = 2 + (CPB - 1) / 2 + 1 + 9 * CPB + 1;

  typedef struct {
    int         cyc;
    logic [7:0] b;
    bit         err;
  } ev_t;

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic [7:0] exp_byte;
    logic       exp_dv;
  } vec_t;

  logic       i_Clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       i_RX_Serial = 1'b1;
  logic       o_RX_DV;
  logic [7:0] o_RX_Byte;
`ifdef UART_RX_FRAME_ERR_EN
  logic       o_Frame_Err;
`endif

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   dbl = 0;
  int   byte_chg = 0;
  logic prev_dv = 1'b0;
  logic [7:0] prev_byte = 8'h00;
  logic [7:0] exp_last = 8'h00;
  ev_t  act_q[$];
  ev_t  exp_q[$];
  vec_t tbl[5];

  uart_rx_byte #(.CLKS_PER_BIT(CPB)) dut (
    .i_Clk       (i_Clk),
    .rst_n       (rst_n),
    .i_RX_Serial (i_RX_Serial),
    .o_RX_DV     (o_RX_DV),
    .o_RX_Byte   (o_RX_Byte)
`ifdef UART_RX_FRAME_ERR_EN
    ,
    .o_Frame_Err (o_Frame_Err)
`endif
  );

  always #5 i_Clk = ~i_Clk;

  always @(posedge i_Clk) begin
    cyc++;
    #1;
    if (o_RX_DV) act_q.push_back('{cyc, o_RX_Byte, 1'b0});
`ifdef UART_RX_FRAME_ERR_EN
    if (o_Frame_Err) act_q.push_back('{cyc, o_RX_Byte, 1'b1});
`endif
    if (o_RX_DV && prev_dv) dbl++;
    if (rst_n && !o_RX_DV && o_RX_Byte != prev_byte) byte_chg++;
    prev_dv   = o_RX_DV;
    prev_byte = o_RX_Byte;
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_rng(input string nm, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d..%0d", nm, act, lo, hi);
    end
  endtask

  task automatic idle(input int n);
    i_RX_Serial = 1'b1;
    repeat (n) @(negedge i_Clk);
  endtask

  task automatic drive_frame(input logic [7:0] d, input logic stop, input int nbits);
    logic [9:0] f;
    f = {stop, d, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      i_RX_Serial = f[i];
      repeat (CPB) @(negedge i_Clk);
    end
    i_RX_Serial = 1'b1;
  endtask

  // Reference: every frame yields one event LAT cycles after its start edge.
  task automatic send(input logic [7:0] d, input logic stop);
    ev_t e;
    e.cyc = cyc + LAT;
    e.b   = d;
    e.err = 1'b0;
`ifdef UART_RX_FRAME_ERR_EN
    if (!stop) begin
      e.err = 1'b1;
      e.b   = exp_last;
    end
`endif
    if (!e.err) exp_last = d;
    exp_q.push_back(e);
    drive_frame(d, stop, 10);
  endtask

  task automatic check_queue(input string nm);
    chk({nm, "_count"}, act_q.size(), exp_q.size());
    for (int i = 0; i < act_q.size() && i < exp_q.size(); i++) begin
      chk({nm, "_kind"}, int'(act_q[i].err), int'(exp_q[i].err));
      chk({nm, "_byte"}, act_q[i].b, exp_q[i].b);
      chk_rng({nm, "_time"}, act_q[i].cyc, exp_q[i].cyc - 1, exp_q[i].cyc + 1);
    end
    act_q.delete();
    exp_q.delete();
  endtask

  initial begin
    int t0, n_dv, n_err, n_brk;
    logic [7:0] d;
    logic s;
    tbl[0] = '{8'hA5, 1'b1, 8'hA5, 1'b1};
`ifdef UART_RX_FRAME_ERR_EN
    tbl[1] = '{8'h3C, 1'b0, 8'hA5, 1'b0};
`else
    tbl[1] = '{8'h3C, 1'b0, 8'h3C, 1'b1};
`endif
    tbl[2] = '{8'h00, 1'b1, 8'h00, 1'b1};
    tbl[3] = '{8'hFF, 1'b1, 8'hFF, 1'b1};
    tbl[4] = '{8'h81, 1'b1, 8'h81, 1'b1};

    repeat (3) @(negedge i_Clk);
    chk("reset_dv", o_RX_DV, 0);
    chk("reset_byte", o_RX_Byte, 0);
`ifdef UART_RX_FRAME_ERR_EN
    chk("reset_ferr", o_Frame_Err, 0);
`endif
    rst_n = 1'b1;
    idle(2 * CPB);
    act_q.delete();

    for (int k = 0; k < 5; k++) begin
      send(tbl[k].data, tbl[k].stop);
      idle(2 * CPB);
      n_dv = 0;
      n_err = 0;
      foreach (act_q[i]) if (act_q[i].err) n_err++; else n_dv++;
      chk($sformatf("tbl%0d_dv", k), n_dv, int'(tbl[k].exp_dv));
      chk($sformatf("tbl%0d_byte", k), o_RX_Byte, tbl[k].exp_byte);
`ifdef UART_RX_FRAME_ERR_EN
      chk($sformatf("tbl%0d_ferr", k), n_err, int'(!tbl[k].exp_dv));
`endif
      check_queue($sformatf("tbl%0d", k));
    end

    t0 = cyc;
    send(8'hA5, 1'b1);
    idle(2 * CPB);
    if (act_q.size() > 0) chk_rng("latency", act_q[0].cyc - t0, LAT - 1, LAT + 1);
    chk("digit2", o_RX_Byte[7:4], 4'hA);
    chk("digit1", o_RX_Byte[3:0], 4'h5);
    check_queue("a5");

    i_RX_Serial = 1'b0;
    repeat (2) @(negedge i_Clk);
    idle(3 * CPB);
    chk("glitch_byte", o_RX_Byte, 8'hA5);
    check_queue("glitch");

    send(8'h00, 1'b1);
    send(8'hFF, 1'b1);
    idle(2 * CPB);
    if (act_q.size() >= 2) chk_rng("b2b_gap", act_q[1].cyc - act_q[0].cyc, 79, 81);
    check_queue("b2b");

    drive_frame(8'h81, 1'b1, 4);
    rst_n = 1'b0;
    #1;
    chk("midrst_dv", o_RX_DV, 0);
    chk("midrst_byte", o_RX_Byte, 0);
    exp_last = 8'h00;
    repeat (3) @(negedge i_Clk);
    rst_n = 1'b1;
    idle(12 * CPB);
    check_queue("midrst_none");
    send(8'h42, 1'b1);
    idle(2 * CPB);
    chk("midrst_42", o_RX_Byte, 8'h42);
    check_queue("after_rst");

    for (int k = 0; k < 24; k++) begin
      d = 8'($urandom_range(0, 255));
      s = ($urandom_range(0, 3) != 0);
      send(d, s);
      idle(s ? $urandom_range(0, 2 * CPB) : $urandom_range(CPB, 2 * CPB));
    end
    idle(2 * CPB);
    check_queue("rand");

    t0 = cyc;
    i_RX_Serial = 1'b0;
    repeat (240) @(negedge i_Clk);
    idle(14 * CPB);
    n_brk = 0;
    foreach (act_q[i]) begin
      if (act_q[i].cyc <= t0 + 240) begin
        n_brk++;
`ifdef UART_RX_FRAME_ERR_EN
        chk("break_kind", int'(act_q[i].err), 1);
`else
        chk("break_kind", int'(act_q[i].err), 0);
        chk("break_byte", act_q[i].b, 8'h00);
`endif
      end
    end
    chk("break_frames", n_brk, 3);

    chk("dv_double", dbl, 0);
    chk("byte_change_without_dv", byte_chg, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
